// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: LED PIO pattern/brightness/fade inputs and PWM LED drive outputs
//   led_pattern: on/off pattern, brightness: lit level, fade_en: ramp enable
//   led_out: PWM drive per LED, busy: some level has not reached its target
interface led_pwm_fader_if #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
);
  logic [NUM_LEDS-1:0] led_pattern;
  logic [PWM_BITS-1:0] brightness;
  logic fade_en;
  logic [NUM_LEDS-1:0] led_out;
  logic busy;
  modport master (output led_pattern, brightness, fade_en, input led_out, busy);
  modport slave (input led_pattern, brightness, fade_en, output led_out, busy);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED PWM drive with global brightness and optional linear fade
//   clk, reset_n (async, active-low); bus.slave carries led_pattern, brightness,
//   fade_en in and registered led_out, busy out
module led_pwm_fader #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 49
) (
  input logic clk,
  input logic reset_n,
  led_pwm_fader_if.slave bus
);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam int PS_W = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE);
  typedef enum logic [1:0] {STEADY, UP, DOWN} state_t;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0] prescaler;
  logic [PWM_BITS-1:0] level [NUM_LEDS];
  logic [PWM_BITS-1:0] target [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  state_t state [NUM_LEDS];
  state_t state_nxt [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit;
  logic [NUM_LEDS-1:0] diff;
  logic period_end;
  logic fade_tick;
  assign period_end = pwm_cnt == CNT_MAX;
  assign fade_tick = period_end && prescaler == PS_MAX;
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i] = pattern_q[i] ? bus.brightness : '0;
      level_nxt[i] = !bus.fade_en ? target[i] :
                     !fade_tick ? level[i] :
                     target[i] > level[i] ? level[i] + 1'b1 :
                     target[i] < level[i] ? level[i] - 1'b1 : level[i];
      // a ramp that reverses mid-way goes straight UP<->DOWN without passing STEADY
      state_nxt[i] = state[i] == STEADY ?
                       (target[i] > level_nxt[i] ? UP : target[i] < level_nxt[i] ? DOWN : STEADY) :
                     level_nxt[i] == target[i] ? STEADY :
                     target[i] > level_nxt[i] ? UP : DOWN;
      diff[i] = level[i] != target[i];
      lit[i] = pwm_cnt < level[i];
    end
  end
  // levels only move on period boundaries so no PWM period is ever cut short
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      pwm_cnt <= '0;
      prescaler <= '0;
      bus.led_out <= '0;
      bus.busy <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
        state[i] <= STEADY;
      end
    end else begin
      pattern_q <= bus.led_pattern;
      pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      if (period_end) begin
        prescaler <= fade_tick ? '0 : prescaler + 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) begin
          level[i] <= level_nxt[i];
          state[i] <= state_nxt[i];
        end
      end
      bus.led_out <= lit;
      bus.busy <= |diff;
    end
  end
endmodule
